// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and types for the BeagleBone command-frame parser.
// Frame layout on the wire: SYNC, CHAN, POS_HI, POS_LO, CHK.
package uart_cmd_parser_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHAN,
        S_HI,
        S_LO,
        S_CHK,
        S_REPLY
    } state_t;

    typedef struct packed {
        logic [3:0]  channel;
        logic [15:0] position;
    } cmd_t;

endpackage

// File: rtl/uart_inactivity_timer.sv
// Counts idle cycles while a frame is open; expired flags the last allowed cycle.
module uart_inactivity_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear || !run) begin
            count_q <= '0;
        end else if (count_q != LAST) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired = run && (count_q == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames from uart_rx, strobes validated commands
// and answers each completed frame with ACK/NAK through uart_tx.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS   = 6,
    parameter logic [15:0] POS_MAX        = 16'd4095,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_converted,
    input  logic        rx_valid,
    output logic        rx_flush,
    input  logic        tx_busy,
    output logic        tx_enable,
    output logic [7:0]  tx_data,
    output logic        cmd_valid,
    output logic [3:0]  cmd_channel,
    output logic [15:0] cmd_position,
    output logic [7:0]  err_count
);

    state_t      state_q, state_d;
    logic        flush_q, flush_d;
    logic        holdoff_q;
    logic        tx_enable_q, tx_enable_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        cmd_valid_q, cmd_valid_d;
    cmd_t        cmd_q, cmd_d;
    logic [7:0]  err_q, err_d;
    logic [7:0]  chan_q, chan_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  chk_q, chk_d;
    logic        ack_q, ack_d;
    logic        err_inc;
    logic        accept, good, bad;
    logic        frame_ok;
    logic        timer_run, expired;

    // A held uart_rx byte is ignored in the flush cycle and the one after,
    // giving uart_rx time to drop rx_converted.
    assign accept   = rx_converted && !flush_q && !holdoff_q && (state_q != S_REPLY);
    assign good     = accept && rx_valid;
    assign bad      = accept && !rx_valid;
    assign frame_ok = (rx_data == chk_q) && (32'(chan_q) < NUM_CHANNELS)
                      && ({hi_q, lo_q} <= POS_MAX);
    assign timer_run = (state_q == S_CHAN) || (state_q == S_HI)
                       || (state_q == S_LO) || (state_q == S_CHK);

    uart_inactivity_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .run    (timer_run),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            flush_q     <= 1'b0;
            holdoff_q   <= 1'b0;
            tx_enable_q <= 1'b0;
            tx_data_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            err_q       <= '0;
            chan_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            chk_q       <= '0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            holdoff_q   <= flush_q;
            tx_enable_q <= tx_enable_d;
            tx_data_q   <= tx_data_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            err_q       <= err_d;
            chan_q      <= chan_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            chk_q       <= chk_d;
            ack_q       <= ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_d     = accept;
        tx_enable_d = 1'b0;
        tx_data_d   = tx_data_q;
        cmd_valid_d = 1'b0;
        cmd_d       = cmd_q;
        chan_d      = chan_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        chk_d       = chk_q;
        ack_d       = ack_q;
        err_inc     = 1'b0;

        if (bad) begin
            state_d = S_IDLE;
            err_inc = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (good && (rx_data == SYNC_BYTE)) begin
                        chk_d   = '0;
                        state_d = S_CHAN;
                    end
                end
                S_CHAN, S_HI, S_LO: begin
                    if (good) begin
                        chk_d = chk_q ^ rx_data;
                        if (state_q == S_CHAN) begin
                            chan_d  = rx_data;
                            state_d = S_HI;
                        end else if (state_q == S_HI) begin
                            hi_d    = rx_data;
                            state_d = S_LO;
                        end else begin
                            lo_d    = rx_data;
                            state_d = S_CHK;
                        end
                    end else if (expired) begin
                        state_d = S_IDLE;
                        err_inc = 1'b1;
                    end
                end
                S_CHK: begin
                    if (good) begin
                        ack_d   = frame_ok;
                        state_d = S_REPLY;
                        if (frame_ok) begin
                            cmd_valid_d    = 1'b1;
                            cmd_d.channel  = chan_q[3:0];
                            cmd_d.position = {hi_q, lo_q};
                        end else begin
                            err_inc = 1'b1;
                        end
                    end else if (expired) begin
                        state_d = S_IDLE;
                        err_inc = 1'b1;
                    end
                end
                S_REPLY: begin
                    if (!tx_busy) begin
                        tx_enable_d = 1'b1;
                        tx_data_d   = ack_q ? ACK_BYTE : NAK_BYTE;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    assign rx_flush     = flush_q;
    assign tx_enable    = tx_enable_q;
    assign tx_data      = tx_data_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_channel  = cmd_q.channel;
    assign cmd_position = cmd_q.position;
    assign err_count    = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frame table, random frames against a frame-level
// model, and hand sequences for timeout, tx backpressure, reset and saturation.
module tb_uart_cmd_parser;

    localparam int unsigned T_OUT = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_converted;
    logic        rx_valid;
    logic        rx_flush;
    logic        tx_busy;
    logic        tx_enable;
    logic [7:0]  tx_data;
    logic        cmd_valid;
    logic [3:0]  cmd_channel;
    logic [15:0] cmd_position;
    logic [7:0]  err_count;

    int vectors     = 0;
    int miscompares = 0;
    int cv_count    = 0;
    int te_count    = 0;

    uart_cmd_parser #(
        .NUM_CHANNELS  (6),
        .POS_MAX       (16'd4095),
        .TIMEOUT_CYCLES(T_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_converted(rx_converted),
        .rx_valid    (rx_valid),
        .rx_flush    (rx_flush),
        .tx_busy     (tx_busy),
        .tx_enable   (tx_enable),
        .tx_data     (tx_data),
        .cmd_valid   (cmd_valid),
        .cmd_channel (cmd_channel),
        .cmd_position(cmd_position),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) cv_count++;
            if (tx_enable) te_count++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Present one byte like uart_rx: hold until flushed plus one more cycle.
    task automatic send_byte(input logic [7:0] d, input logic v,
                             output logic cv, output logic [3:0] ch, output logic [15:0] pos,
                             output logic te, output logic [7:0] td, output logic cv2);
        bit seen = 0;
        cv = 0; ch = 0; pos = 0; te = 0; td = 0; cv2 = 0;
        rx_data = d; rx_valid = v; rx_converted = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (rx_flush) seen = 1;
        end
        if (!seen) begin
            check("flush_wait", 32'(seen), 32'd1);
            rx_converted = 1'b0;
            return;
        end
        cv = cmd_valid; ch = cmd_channel; pos = cmd_position;
        @(negedge clk);
        te = tx_enable; td = tx_data; cv2 = cmd_valid;
        @(negedge clk);
        rx_converted = 1'b0;
    endtask

    task automatic put(input logic [7:0] d, input logic v);
        logic cv, te, cv2;
        logic [3:0] ch;
        logic [15:0] pos;
        logic [7:0] td;
        send_byte(d, v, cv, ch, pos, te, td, cv2);
    endtask

    logic [3:0]  last_ch;
    logic [15:0] last_pos;
    int          err_model;

    // Send a whole frame with tx idle and check strobe, reply and counters.
    task automatic apply_frame(input string name, input logic [39:0] f, input logic exp_ack,
                               input logic [3:0] exp_ch, input logic [15:0] exp_pos,
                               input logic [7:0] exp_err);
        logic cv, te, cv2;
        logic [3:0] ch;
        logic [15:0] pos;
        logic [7:0] td;
        for (int k = 4; k >= 1; k--) put(f[k*8 +: 8], 1'b1);
        send_byte(f[7:0], 1'b1, cv, ch, pos, te, td, cv2);
        if (exp_ack) begin
            last_ch  = exp_ch;
            last_pos = exp_pos;
        end
        check({name, "_cmd_valid"}, 32'(cv), 32'(exp_ack));
        check({name, "_channel"}, 32'(ch), 32'(last_ch));
        check({name, "_position"}, 32'(pos), 32'(last_pos));
        check({name, "_cv_one_cycle"}, 32'(cv2), 32'd0);
        check({name, "_tx_enable"}, 32'(te), 32'd1);
        check({name, "_tx_data"}, 32'(td), exp_ack ? 32'h06 : 32'h15);
        check({name, "_err_count"}, 32'(err_count), 32'(exp_err));
    endtask

    function automatic logic ref_ack(input logic [39:0] f);
        int chan, pos;
        chan = int'(f[31:24]);
        pos  = int'(f[23:16]) * 256 + int'(f[15:8]);
        return (f[7:0] == (f[31:24] ^ f[23:16] ^ f[15:8])) && (chan < 6) && (pos <= 4095);
    endfunction

    typedef struct {
        logic [39:0] frame;
        logic        exp_ack;
        logic [3:0]  exp_ch;
        logic [15:0] exp_pos;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic cv, te, cv2;
        logic [3:0] ch;
        logic [15:0] pos;
        logic [7:0] td;
        logic [7:0] chan, hi, lo, chk;
        logic [39:0] f;
        logic ack;
        int cv0, te0, bad_cnt;
        bit seen;

        tbl[0] = '{40'hA5_02_01_F4_F7, 1'b1, 4'd2, 16'h01F4, 8'd0};
        tbl[1] = '{40'hA5_02_01_F4_00, 1'b0, 4'd0, 16'h0000, 8'd1};
        tbl[2] = '{40'hA5_07_00_10_17, 1'b0, 4'd0, 16'h0000, 8'd2};
        tbl[3] = '{40'hA5_00_10_00_10, 1'b0, 4'd0, 16'h0000, 8'd3};
        tbl[4] = '{40'hA5_05_0F_FF_F5, 1'b1, 4'd5, 16'h0FFF, 8'd3};
        tbl[5] = '{40'hA5_06_00_00_06, 1'b0, 4'd0, 16'h0000, 8'd4};
        tbl[6] = '{40'hA5_00_00_A5_A5, 1'b1, 4'd0, 16'h00A5, 8'd4};
        tbl[7] = '{40'hA5_00_00_00_00, 1'b1, 4'd0, 16'h0000, 8'd4};

        rst = 1'b1; rx_data = '0; rx_converted = 1'b0; rx_valid = 1'b0; tx_busy = 1'b0;
        last_ch = '0; last_pos = '0; err_model = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {tx_enable, rx_flush, cmd_valid, tx_data, cmd_channel,
                                cmd_position[7:0], err_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i])
            apply_frame($sformatf("tbl%0d", i), tbl[i].frame, tbl[i].exp_ack,
                        tbl[i].exp_ch, tbl[i].exp_pos, tbl[i].exp_err);
        err_model = 4;

        // Receive error mid-frame aborts silently; leftover bytes are discarded.
        cv0 = cv_count; te0 = te_count;
        put(8'hA5, 1'b1); put(8'h02, 1'b1); put(8'h01, 1'b0);
        err_model++;
        put(8'h01, 1'b1); put(8'hF4, 1'b1); put(8'hF7, 1'b1);
        check("rxerr_err_count", 32'(err_count), 32'(err_model));
        check("rxerr_no_output", 32'(cv_count - cv0 + te_count - te0), 32'd0);
        apply_frame("rxerr_recover", 40'hA5_03_00_05_06, 1'b1, 4'd3, 16'h0005, 8'(err_model));

        // Inactivity timeout after a partial frame.
        te0 = te_count;
        put(8'hA5, 1'b1); put(8'h01, 1'b1);
        repeat (T_OUT - 3) @(negedge clk);
        check("timeout_not_early", 32'(err_count), 32'(err_model));
        @(negedge clk);
        err_model++;
        check("timeout_err_count", 32'(err_count), 32'(err_model));
        repeat (5) @(negedge clk);
        check("timeout_no_reply", 32'(te_count - te0), 32'd0);
        apply_frame("timeout_recover", 40'hA5_02_01_F4_F7, 1'b1, 4'd2, 16'h01F4, 8'(err_model));

        // Reply held off by tx_busy; a new byte waits unflushed meanwhile.
        tx_busy = 1'b1;
        te0 = te_count;
        put(8'hA5, 1'b1); put(8'h04, 1'b1); put(8'h02, 1'b1); put(8'h10, 1'b1);
        send_byte(8'h16, 1'b1, cv, ch, pos, te, td, cv2);
        check("busy_cmd_valid", 32'(cv), 32'd1);
        check("busy_cmd", {12'd0, ch, pos}, {12'd0, 4'd4, 16'h0210});
        check("busy_no_early_tx", 32'(te), 32'd0);
        rx_data = 8'h33; rx_valid = 1'b1; rx_converted = 1'b1;
        bad_cnt = 0;
        repeat (45) begin
            @(negedge clk);
            if (rx_flush || tx_enable) bad_cnt++;
        end
        check("busy_stall", 32'(bad_cnt), 32'd0);
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_tx_enable", 32'(tx_enable), 32'd1);
        check("busy_tx_data", 32'(tx_data), 32'h06);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rx_flush) seen = 1;
        end
        check("busy_pending_flushed", 32'(seen), 32'd1);
        @(negedge clk); @(negedge clk);
        rx_converted = 1'b0;
        check("busy_single_reply", 32'(te_count - te0), 32'd1);
        last_ch = 4'd4; last_pos = 16'h0210;

        // Random frames against the frame-level model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) put(8'($urandom_range(0, 8'hA4)), 1'b1);
            chan = 8'($urandom_range(0, 8));
            hi   = 8'($urandom_range(0, 17));
            lo   = 8'($urandom);
            chk  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (chan ^ hi ^ lo);
            f    = {8'hA5, chan, hi, lo, chk};
            ack  = ref_ack(f);
            if (!ack && err_model < 255) err_model++;
            apply_frame($sformatf("rnd%0d", n), f, ack, chan[3:0], {hi, lo}, 8'(err_model));
        end

        // Asynchronous reset mid-frame, then orphaned frame tail and saturation.
        put(8'hA5, 1'b1); put(8'h03, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_outputs", {tx_enable, rx_flush, cmd_valid, tx_data, cmd_channel,
                                 cmd_position[7:0], err_count}, 32'd0);
        check("midrst_position", 32'(cmd_position), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cv0 = cv_count; te0 = te_count;
        put(8'h03, 1'b1); put(8'h00, 1'b1); put(8'h05, 1'b1); put(8'h06, 1'b1);
        repeat (4) @(negedge clk);
        check("orphan_no_output", 32'(cv_count - cv0 + te_count - te0), 32'd0);
        check("orphan_err_count", 32'(err_count), 32'd0);
        for (int i = 0; i < 300; i++) begin
            put(8'($urandom), 1'b0);
            if (i == 253) check("sat_254", 32'(err_count), 32'd254);
        end
        check("sat_ff", 32'(err_count), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
